// File: rtl/reaction_timer_core.sv
// reaction_timer_core: randomised stimulus delay then ms reaction measurement with false-start/timeout handling.
// Define REACTION_TIMER_BEST_EN to keep a best-time register recalled by pressing in DONE.
module reaction_timer_core #(
    parameter int CLKS_PER_MS = 10000,
    parameter int MIN_WAIT_MS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        start,
    output logic        stim_led,
    output logic        busy,
    output logic [13:0] value,
    output logic        show_error
);
    localparam int PW = $clog2(CLKS_PER_MS);
    typedef enum logic [2:0] {IDLE, WAIT, MEASURE, DONE, ERROR} state_t;
    state_t state, state_d;
    logic [15:0] lfsr;
    logic [2:0] sync;
    logic [PW-1:0] pre;
    logic [14:0] wait_ms, wait_d;
    logic [13:0] elapsed, elapsed_d, last, last_d, value_d;
    logic press, tick, clr, launch;
`ifdef REACTION_TIMER_BEST_EN
    logic [13:0] best, best_d;
    logic show_best, show_d;
`endif
    assign press = sync[1] & ~sync[2];
    assign tick = pre == PW'(CLKS_PER_MS - 1);
    assign launch = start && (state == IDLE || state == DONE || state == ERROR);
    always_comb begin
        state_d = state;
        wait_d = wait_ms;
        elapsed_d = elapsed;
        last_d = last;
        clr = 1'b0;
`ifdef REACTION_TIMER_BEST_EN
        best_d = best;
        show_d = show_best;
`endif
        if (launch) begin
            state_d = WAIT;
            wait_d = 15'(MIN_WAIT_MS) + {4'd0, lfsr[10:0]};
            last_d = 14'd0;
            clr = 1'b1;
`ifdef REACTION_TIMER_BEST_EN
            show_d = 1'b0;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (press) begin
                        state_d = ERROR;
                    end else if (tick) begin
                        if (wait_ms == 15'd1) begin
                            state_d = MEASURE;
                            elapsed_d = 14'd0;
                            clr = 1'b1;
                        end else begin
                            wait_d = wait_ms - 15'd1;
                        end
                    end
                end
                MEASURE: begin
                    if (press) begin
                        state_d = DONE;
                        last_d = elapsed;
`ifdef REACTION_TIMER_BEST_EN
                        best_d = (elapsed < best) ? elapsed : best;
`endif
                    end else if (tick) begin
                        if (elapsed == 14'd9998) begin
                            state_d = DONE;
                            last_d = 14'd9999;
                        end else begin
                            elapsed_d = (elapsed == 14'd9999) ? elapsed : elapsed + 14'd1;
                        end
                    end
                end
`ifdef REACTION_TIMER_BEST_EN
                DONE: show_d = press ? !show_best : show_best;
`endif
                default: ;
            endcase
        end
`ifdef REACTION_TIMER_BEST_EN
        value_d = show_d ? best_d : last_d;
`else
        value_d = last_d;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lfsr <= 16'hACE1;
            sync <= 3'd0;
            pre <= '0;
            wait_ms <= 15'd0;
            elapsed <= 14'd0;
            last <= 14'd0;
            value <= 14'd0;
            stim_led <= 1'b0;
            busy <= 1'b0;
            show_error <= 1'b0;
`ifdef REACTION_TIMER_BEST_EN
            best <= 14'd9999;
            show_best <= 1'b0;
`endif
        end else begin
            state <= state_d;
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            sync <= {sync[1:0], btn};
            // restart on WAIT/MEASURE entry so the first ms is always full length
            pre <= (clr || tick) ? '0 : pre + PW'(1);
            wait_ms <= wait_d;
            elapsed <= elapsed_d;
            last <= last_d;
            value <= value_d;
            stim_led <= state_d == MEASURE;
            busy <= state_d == WAIT || state_d == MEASURE;
            show_error <= state_d == ERROR;
`ifdef REACTION_TIMER_BEST_EN
            best <= best_d;
            show_best <= show_d;
`endif
        end
    end
endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core: directed scenario tests with CLKS_PER_MS=4, MIN_WAIT_MS=2.
module tb_reaction_timer_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0;
    logic start = 1'b0;
    logic stim_led, busy, show_error;
    logic [13:0] value;
    logic [15:0] lfsr_m;
    int exp_wait, n_checks, n_fail;

    reaction_timer_core #(.CLKS_PER_MS(4), .MIN_WAIT_MS(2)) dut (
        .clk(clk), .reset(reset), .btn(btn), .start(start),
        .stim_led(stim_led), .busy(busy), .value(value), .show_error(show_error)
    );

    always #5 clk = ~clk;

    // free-running reference of the stimulus-delay generator
    always @(posedge clk)
        lfsr_m <= reset ? 16'hACE1 : ({1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        exp_wait = 2 + int'(lfsr_m[10:0]);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_stim(output int n);
        n = 0;
        while (!stim_led && n < 10000) begin
            step(1);
            n++;
        end
    endtask

    task automatic press_after(input int k);
        step(k);
        btn = 1'b1;
        step(3);
        btn = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        n_checks++;
        if ({stim_led, busy, show_error, value} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {stim_led, busy, show_error, value});
        end
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            step(4);
            btn = 1'b0;
            step(4);
        end
        n_checks++;
        if ({stim_led, busy, show_error, value} !== 17'd0) begin
            n_fail++;
            $display("FAIL idle_press: got %h required 0", {stim_led, busy, show_error, value});
        end
    endtask

    task automatic test_normal();
        int n;
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || stim_led !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy: got busy=%b stim=%b required busy=1 stim=0", busy, stim_led);
        end
        wait_stim(n);
        n_checks++;
        if (n != exp_wait * 4) begin
            n_fail++;
            $display("FAIL normal_delay: got %0d required %0d", n, exp_wait * 4);
        end
        n_checks++;
        if (n < 8 || n > 2049 * 4) begin
            n_fail++;
            $display("FAIL delay_range: got %0d required 8..8196", n);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL measure_busy: got %b required 1", busy);
        end
        press_after(20);
        n_checks++;
        if (value !== 14'd5) begin
            n_fail++;
            $display("FAIL normal_value: got %0d required 5", value);
        end
        n_checks++;
        if ({busy, stim_led, show_error} !== 3'b000) begin
            n_fail++;
            $display("FAIL normal_done: got %b required 000", {busy, stim_led, show_error});
        end
    endtask

    task automatic test_false_start();
        int highs = 0;
        pulse_start();
        step(2);
        btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (stim_led) highs++;
        end
        n_checks++;
        if (show_error !== 1'b1 || value !== 14'd0) begin
            n_fail++;
            $display("FAIL false_start: got err=%b value=%0d required err=1 value=0", show_error, value);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL error_busy: got %b required 0", busy);
        end
        btn = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (stim_led) highs++;
        end
        n_checks++;
        if (highs != 0) begin
            n_fail++;
            $display("FAIL error_no_stim: got %0d stim cycles required 0", highs);
        end
        pulse_start();
        n_checks++;
        if (show_error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL error_restart: got err=%b busy=%b required err=0 busy=1", show_error, busy);
        end
    endtask

    task automatic test_timeout();
        int n, m;
        wait_stim(n);
        n_checks++;
        if (n != exp_wait * 4) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d required %0d", n, exp_wait * 4);
        end
        m = 0;
        while (stim_led && m < 45000) begin
            step(1);
            m++;
        end
        n_checks++;
        if (m != 39996) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d required 39996", m);
        end
        n_checks++;
        if (value !== 14'd9999 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_value: got value=%0d busy=%b required 9999 0", value, busy);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        pulse_start();
        wait_stim(n);
        step(10);
        reset = 1'b1;
        step(1);
        n_checks++;
        if ({stim_led, busy, show_error, value} !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required 0", {stim_led, busy, show_error, value});
        end
        reset = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_stim(n);
        n_checks++;
        if (n != 5004) begin
            n_fail++;
            $display("FAIL seed_delay: got %0d required 5004", n);
        end
    endtask

    task automatic test_best();
        int n;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        pulse_start();
        wait_stim(n);
        press_after(27);
        n_checks++;
        if (value !== 14'd7) begin
            n_fail++;
            $display("FAIL best_trial1: got %0d required 7", value);
        end
        pulse_start();
        wait_stim(n);
        press_after(47);
        n_checks++;
        if (value !== 14'd12) begin
            n_fail++;
            $display("FAIL best_trial2: got %0d required 12", value);
        end
        press_after(0);
`ifdef REACTION_TIMER_BEST_EN
        n_checks++;
        if (value !== 14'd7) begin
            n_fail++;
            $display("FAIL best_show: got %0d required 7", value);
        end
`else
        n_checks++;
        if (value !== 14'd12) begin
            n_fail++;
            $display("FAIL done_press_ignored: got %0d required 12", value);
        end
`endif
        press_after(0);
        n_checks++;
        if (value !== 14'd12 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL best_toggle_back: got value=%0d busy=%b required 12 0", value, busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_normal();
        test_false_start();
        test_timeout();
        test_mid_reset();
        test_best();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
